// File: rtl/fifo_loop_ctrl_pkg.sv
// Shared definitions for the UART loopback FIFO sequencer: frame size,
// counter width, pacing default, one-hot state encoding and test pattern.
package loop_pkg;

    localparam int DEPTH  = 256;  // bytes per test frame
    localparam int CNT_W  = 9;    // 2**CNT_W must exceed DEPTH
    localparam int RD_GAP = 4;    // idle cycles between FIFO reads
    localparam int GAP_W  = 4;    // width of the gap down-counter (RD_GAP <= 15)

    localparam logic [7:0] PAT_START = 8'h00;  // first byte of the expected pattern

    // One-hot bit positions of the sequencer states
    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_GAP   = 2;
    localparam int S_READ  = 3;
    localparam int S_CHECK = 4;
    localparam int S_DONE  = 5;
    localparam int ST_W    = 6;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = ST_W'(1 << S_IDLE),
        ST_FILL  = ST_W'(1 << S_FILL),
        ST_GAP   = ST_W'(1 << S_GAP),
        ST_READ  = ST_W'(1 << S_READ),
        ST_CHECK = ST_W'(1 << S_CHECK),
        ST_DONE  = ST_W'(1 << S_DONE)
    } state_e;

    // Next value of the incrementing test pattern (wraps at 0xFF)
    function automatic logic [7:0] next_pattern(input logic [7:0] b);
        return b + 8'd1;
    endfunction

endpackage

// File: rtl/fifo_loop_ctrl_if.sv
// Byte-stream bus between uart_rx, the sequencer and the 256x8 FIFO.
// The master side is the sequencer; the slave side is the receiver/FIFO pair.
interface fifo_loop_ctrl_if;

    logic [7:0] rx_data;       // received byte
    logic       rx_valid;      // one-cycle strobe qualifying rx_data
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;  // valid one cycle after fifo_rd_en
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_rd_en;

    modport master (
        input  rx_data, rx_valid, fifo_full, fifo_empty, fifo_rd_data,
        output fifo_wr_en, fifo_wr_data, fifo_rd_en
    );

    modport slave (
        output rx_data, rx_valid, fifo_full, fifo_empty, fifo_rd_data,
        input  fifo_wr_en, fifo_wr_data, fifo_rd_en
    );

endinterface

// File: rtl/fifo_loop_ctrl_gap_timer.sv
// Load/expire down-counter that paces FIFO reads. Loaded on entry to GAP,
// counts down while enabled and reports expiry when it reaches zero.
module gap_timer
    import loop_pkg::*;
#(
    parameter int W = GAP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_loop_ctrl.sv
// UART loopback FIFO test sequencer: fills the FIFO with one frame of DEPTH
// received bytes, then drains it at a paced rate and checks each byte
// against an incrementing pattern, reporting pass/fail and error counts.
module fifo_loop_ctrl #(
    parameter int DEPTH  = loop_pkg::DEPTH,
    parameter int CNT_W  = loop_pkg::CNT_W,
    parameter int RD_GAP = loop_pkg::RD_GAP
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    fifo_loop_ctrl_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             ovf,
    output logic             unf,
    output logic [7:0]       chk_byte,
    output logic             chk_valid
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    // GAP occupies RD_GAP cycles; with RD_GAP = 0 the CHECK->READ path skips
    // GAP altogether so that read pacing stays at RD_GAP + 2 cycles per byte.
    localparam logic [loop_pkg::GAP_W-1:0] GAP_LD =
        (RD_GAP == 0) ? '0 : loop_pkg::GAP_W'(RD_GAP - 1);

    loop_pkg::state_e state_q, state_d;

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       chk_byte_q, chk_byte_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             rd_en;
    logic             gap_load;
    logic             gap_expired;
    logic             in_check;

    gap_timer #(
        .W (loop_pkg::GAP_W)
    ) u_gap_timer (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .load_i     (gap_load),
        .load_val_i (GAP_LD),
        .en_i       (state_q == loop_pkg::ST_GAP),
        .expired_o  (gap_expired)
    );

    // Next-state, counter updates and strobe generation
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        err_cnt_d  = err_cnt_q;
        exp_d      = exp_q;
        chk_byte_d = chk_byte_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        rd_en      = 1'b0;
        gap_load   = 1'b0;

        case (state_q)
            loop_pkg::ST_IDLE, loop_pkg::ST_DONE: begin
                // rx_valid here is deliberately ignored, even alongside start
                if (start) begin
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    err_cnt_d = '0;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    exp_d     = loop_pkg::PAT_START;
                    state_d   = loop_pkg::ST_FILL;
                end
            end

            loop_pkg::ST_FILL: begin
                if (wr_cnt_q == DEPTH_C) begin
                    state_d  = loop_pkg::ST_GAP;
                    gap_load = 1'b1;
                end else if (bus.rx_valid) begin
                    // A dropped byte still counts, so the frame length is fixed
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (bus.fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = bus.rx_data;
                    end
                end
            end

            loop_pkg::ST_GAP: begin
                if (gap_expired) begin
                    state_d = loop_pkg::ST_READ;
                end
            end

            loop_pkg::ST_READ: begin
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = loop_pkg::ST_CHECK;
                end else begin
                    unf_d   = 1'b1;
                    state_d = loop_pkg::ST_DONE;
                end
            end

            loop_pkg::ST_CHECK: begin
                chk_byte_d = bus.fifo_rd_data;
                if ((bus.fifo_rd_data != exp_q) && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                exp_d    = loop_pkg::next_pattern(exp_q);
                rd_cnt_d = rd_cnt_q + 1'b1;
                if ((rd_cnt_q + 1'b1) == DEPTH_C) begin
                    state_d = loop_pkg::ST_DONE;
                end else if (RD_GAP == 0) begin
                    state_d = loop_pkg::ST_READ;
                end else begin
                    state_d  = loop_pkg::ST_GAP;
                    gap_load = 1'b1;
                end
            end

            default: state_d = loop_pkg::ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= loop_pkg::ST_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            err_cnt_q  <= '0;
            exp_q      <= loop_pkg::PAT_START;
            chk_byte_q <= 8'h00;
            wr_data_q  <= 8'h00;
            wr_en_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            err_cnt_q  <= err_cnt_d;
            exp_q      <= exp_d;
            chk_byte_q <= chk_byte_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // The FIFO presents read data in CHECK, so the debug byte is shown
    // straight through there and held from the register afterwards.
    assign in_check = (state_q == loop_pkg::ST_CHECK);

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.fifo_rd_en   = rd_en;

    assign busy      = state_q[loop_pkg::S_FILL] | state_q[loop_pkg::S_GAP] |
                       state_q[loop_pkg::S_READ] | state_q[loop_pkg::S_CHECK];
    assign done      = state_q[loop_pkg::S_DONE];
    assign pass      = done && (err_cnt_q == '0) && !ovf_q && !unf_q;
    assign err_cnt   = err_cnt_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign chk_valid = in_check;
    assign chk_byte  = in_check ? bus.fifo_rd_data : chk_byte_q;

endmodule

// File: tb/tb_fifo_loop_ctrl.sv
// Directed bench for fifo_loop_ctrl: a behavioural 256x8 FIFO closes the
// loop, stimulus sends incrementing frames with planted faults, and the
// status outputs and strobe counts are compared with hand-derived values.
module tb_fifo_loop_ctrl;

    localparam int N    = 256;
    localparam int GAPC = 4;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start;
    logic       busy, done, pass, ovf, unf, chk_valid;
    logic [8:0] err_cnt;
    logic [7:0] chk_byte;

    fifo_loop_ctrl_if bus();

    fifo_loop_ctrl #(
        .DEPTH  (N),
        .CNT_W  (9),
        .RD_GAP (GAPC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .ovf       (ovf),
        .unf       (unf),
        .chk_byte  (chk_byte),
        .chk_valid (chk_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- FIFO model (standard mode, registered read) ----------
    logic [7:0] mem [N];
    int         fcnt, wp, rp;
    logic [7:0] rd_q;
    logic       force_full, force_empty;
    logic       fw, fr;

    assign fw               = bus.fifo_wr_en && (fcnt < N);
    assign fr               = bus.fifo_rd_en && (fcnt > 0);
    assign bus.fifo_full    = force_full  | (fcnt == N);
    assign bus.fifo_empty   = force_empty | (fcnt == 0);
    assign bus.fifo_rd_data = rd_q;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fcnt <= 0;
            wp   <= 0;
            rp   <= 0;
            rd_q <= 8'h00;
        end else begin
            if (fw) begin
                mem[wp] <= bus.fifo_wr_data;
                wp      <= (wp + 1) % N;
            end
            if (fr) begin
                rd_q <= mem[rp];
                rp   <= (rp + 1) % N;
            end
            fcnt <= fcnt + (fw ? 1 : 0) - (fr ? 1 : 0);
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    int         cyc = 0, wr_pulses = 0, chk_pulses = 0;
    int         order_err = 0, lat_err = 0, gap_err = 0, last_chk = -1;
    logic       prev_rxv = 1'b0, prev_rd = 1'b0;
    logic [7:0] prev_rxd = 8'h00;

    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (bus.fifo_wr_en) begin
            wr_pulses = wr_pulses + 1;
            if (!prev_rxv || (bus.fifo_wr_data != prev_rxd)) lat_err = lat_err + 1;
        end
        if (chk_valid) begin
            if (!prev_rd) lat_err = lat_err + 1;
            if (chk_byte != 8'(chk_pulses)) order_err = order_err + 1;
            if ((last_chk >= 0) && (cyc - last_chk != GAPC + 2)) gap_err = gap_err + 1;
            last_chk   = cyc;
            chk_pulses = chk_pulses + 1;
        end
        prev_rxv = bus.rx_valid;
        prev_rxd = bus.rx_data;
        prev_rd  = bus.fifo_rd_en;
    end

    // ---------------- checking ---------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {busy, done, pass, ovf, unf, chk_valid, bus.fifo_wr_en, bus.fifo_rd_en,
                err_cnt, chk_byte, bus.fifo_wr_data};
    endfunction

    task automatic clear_stats();
        wr_pulses  = 0;
        chk_pulses = 0;
        order_err  = 0;
        lat_err    = 0;
        gap_err    = 0;
        last_chk   = -1;
    endtask

    task automatic pulse_start(input logic with_rx);
        @(posedge sys_clk); #1;
        start        = 1'b1;
        bus.rx_valid = with_rx;
        bus.rx_data  = 8'hAA;
        @(posedge sys_clk); #1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    // One frame 0x00..0xFF, one byte every two cycles, with optional faults
    task automatic send_frame(input int bad_idx, input int full_idx, input int restart_idx);
        for (int i = 0; i < N; i++) begin
            @(posedge sys_clk); #1;
            bus.rx_valid = 1'b1;
            bus.rx_data  = (i == bad_idx) ? 8'hFF : 8'(i);
            force_full   = (i == full_idx);
            start        = (i == restart_idx);
            @(posedge sys_clk); #1;
            bus.rx_valid = 1'b0;
            force_full   = 1'b0;
            start        = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && (k < 6000)) begin
            @(posedge sys_clk); #1;
            k = k + 1;
        end
        check(tag, done, 1);
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        sys_rst_n    = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        force_full   = 1'b0;
        force_empty  = 1'b0;

        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_outputs", outs(), 0);
        sys_rst_n = 1'b1;

        // Bytes arriving in IDLE must not reach the FIFO
        @(posedge sys_clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        @(posedge sys_clk); #1;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("idle_rx_writes", wr_pulses, 0);
        check("idle_busy", busy, 0);

        // Clean run; start coincides with a byte that must be dropped
        clear_stats();
        pulse_start(1'b1);
        check("fill_busy", busy, 1);
        send_frame(-1, -1, -1);
        wait_done("clean_done");
        check("clean_wr", wr_pulses, 256);
        check("clean_chk", chk_pulses, 256);
        check("clean_order", order_err, 0);
        check("clean_latency", lat_err, 0);
        check("clean_pacing", gap_err, 0);
        check("clean_status", {pass, ovf, unf, err_cnt}, {1'b1, 1'b0, 1'b0, 9'd0});
        check("clean_last_byte", chk_byte, 8'hFF);

        // Byte 17 corrupted
        clear_stats();
        pulse_start(1'b0);
        send_frame(17, -1, -1);
        wait_done("corrupt_done");
        check("corrupt_chk", chk_pulses, 256);
        check("corrupt_order", order_err, 1);
        check("corrupt_status", {pass, ovf, unf, err_cnt}, {1'b0, 1'b0, 1'b0, 9'd1});

        // FIFO full while byte 100 arrives: dropped, later reads shift by one
        // (reads 100..254 mismatch) and the last read finds the FIFO empty
        clear_stats();
        pulse_start(1'b0);
        send_frame(-1, 100, -1);
        wait_done("ovf_done");
        check("ovf_wr", wr_pulses, 255);
        check("ovf_chk", chk_pulses, 255);
        check("ovf_status", {pass, ovf, unf, err_cnt}, {1'b0, 1'b1, 1'b1, 9'd155});

        // Second start mid-FILL is ignored
        clear_stats();
        pulse_start(1'b0);
        send_frame(-1, -1, 60);
        wait_done("restart_done");
        check("restart_wr", wr_pulses, 256);
        check("restart_chk", chk_pulses, 256);
        check("restart_status", {pass, ovf, unf, err_cnt}, {1'b1, 1'b0, 1'b0, 9'd0});

        // Reset asserted while in READ
        clear_stats();
        pulse_start(1'b0);
        send_frame(-1, -1, -1);
        begin
            int k = 0;
            while (!(bus.fifo_rd_en && (chk_pulses >= 10)) && (k < 4000)) begin
                @(posedge sys_clk); #1;
                k = k + 1;
            end
        end
        check("reached_read", bus.fifo_rd_en, 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", outs(), 0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        // Clean run after the abort
        clear_stats();
        pulse_start(1'b0);
        send_frame(-1, -1, -1);
        wait_done("post_reset_done");
        check("post_reset_chk", chk_pulses, 256);
        check("post_reset_status", {pass, ovf, unf, err_cnt}, {1'b1, 1'b0, 1'b0, 9'd0});

        // FIFO reports empty after 50 reads
        clear_stats();
        pulse_start(1'b0);
        send_frame(-1, -1, -1);
        begin
            int k = 0;
            while ((chk_pulses < 50) && (k < 4000)) begin
                @(posedge sys_clk); #1;
                k = k + 1;
            end
        end
        force_empty = 1'b1;
        wait_done("unf_done");
        check("unf_chk", chk_pulses, 50);
        check("unf_status", {pass, ovf, unf, err_cnt}, {1'b0, 1'b0, 1'b1, 9'd0});
        check("unf_idle", busy, 0);
        force_empty = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
